// File: rtl/cmd_deserializer.sv
// SPI-style slave: shifts in one opcode/key/text/dest frame per chip-select window
// and presents it to the request queue through a single holding register with valid/ready.
module cmd_deserializer #(
    parameter int ADDRW       = 24,
    parameter int OPCODEW     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sclk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    input  logic               ready_in_aes,
    input  logic               ready_in_sha,
    output logic               valid_out,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic [ADDRW-1:0]   dest_addr,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun_err
);

    localparam int INSTRW = 3*ADDRW + OPCODEW;
    localparam int CNTW   = $clog2(INSTRW + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(INSTRW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, cs_fall, cs_rise;
    logic                   accept;
    state_t                 state;
    logic [CNTW-1:0]        cnt;
    logic [INSTRW-1:0]      shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // mosi shares the sclk pipeline depth, so it is sampled exactly where sclk rose
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    assign accept = valid_out & (opcode[0] ? ready_in_sha : ready_in_aes);
    assign busy   = valid_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            valid_out   <= 1'b0;
            opcode      <= '0;
            key_addr    <= '0;
            text_addr   <= '0;
            dest_addr   <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (accept) begin
                valid_out <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shreg <= {shreg[INSTRW-2:0], mosi_s};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    // a same-cycle accept frees the holding register for this frame
                    if (!valid_out || accept) begin
                        valid_out <= 1'b1;
                        opcode    <= shreg[INSTRW-1 -: OPCODEW];
                        key_addr  <= shreg[3*ADDRW-1 -: ADDRW];
                        text_addr <= shreg[2*ADDRW-1 -: ADDRW];
                        dest_addr <= shreg[ADDRW-1:0];
                    end else begin
                        overrun_err <= 1'b1;
                    end
                    state <= cs_rise ? IDLE : DONE;
                end
                DONE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_deserializer.sv
// Bench for cmd_deserializer: directed scenarios plus random frames/ready, checked every cycle
// against a transaction-level model of the holding register.
module tb_cmd_deserializer;

    localparam int ADDRW  = 24;
    localparam int INSTRW = 74;

    logic              clk;
    logic              rst;
    logic              spi_sclk, spi_cs_n, spi_mosi;
    logic              ready_in_aes, ready_in_sha;
    logic              valid_out, busy, frame_err, overrun_err;
    logic [1:0]        opcode;
    logic [ADDRW-1:0]  key_addr, text_addr, dest_addr;

    cmd_deserializer #(.ADDRW(24), .OPCODEW(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .ready_in_aes(ready_in_aes), .ready_in_sha(ready_in_sha),
        .valid_out(valid_out), .opcode(opcode),
        .key_addr(key_addr), .text_addr(text_addr), .dest_addr(dest_addr),
        .busy(busy), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scheduled effects of the SPI driver, expressed as the clk cycle they become visible
    int                cyc = 0;
    int                commit_due = -1;
    int                ferr_due = -1;
    logic [INSTRW-1:0] pend_instr = '0;
    event              ev_last;

    // Reference model: one holding register plus a log of delivered instructions
    logic              m_valid;
    logic [INSTRW-1:0] m_instr;
    logic              m_ferr, m_ovr;
    bit                acc;
    logic [INSTRW-1:0] delivered[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_instr = '0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            cyc++;
            acc    = m_valid && (m_instr[72] ? ready_in_sha : ready_in_aes);
            m_ferr = (cyc == ferr_due);
            m_ovr  = 1'b0;
            if (acc) delivered.push_back(m_instr);
            if (cyc == commit_due) begin
                if (!m_valid || acc) begin
                    m_instr = pend_instr;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (acc) begin
                m_valid = 1'b0;
            end
        end
    end

    int checks = 0;
    int passed = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    bit stop_rand = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [INSTRW-1:0] mk(input logic [1:0] op, input logic [23:0] k,
                                             input logic [23:0] t, input logic [23:0] d);
        return {op, k, t, d};
    endfunction

    task automatic compare_loop();
        logic [77:0] a, e;
        forever begin
            @(negedge clk);
            a = {valid_out, busy, frame_err, overrun_err,
                 m_valid ? {opcode, key_addr, text_addr, dest_addr} : 74'd0};
            e = {m_valid, m_valid, m_ferr, m_ovr, m_valid ? m_instr : 74'd0};
            chk($sformatf("cycle%0d", cyc), {50'd0, a}, {50'd0, e});
            ferr_seen += int'(frame_err);
            ovr_seen  += int'(overrun_err);
        end
    endtask

    task automatic send_frame(input logic [INSTRW-1:0] f, input int nbits, input bit hold_cs);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < INSTRW) ? f[INSTRW-1-i] : 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            if (i == INSTRW-1) begin
                commit_due = cyc + 4;
                pend_instr = f;
                ->ev_last;
            end
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        if (!hold_cs) begin
            repeat (4) @(negedge clk);
            spi_cs_n = 1'b1;
            if (nbits < INSTRW) ferr_due = cyc + 3;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 2000 && !valid_out; i++) @(negedge clk);
        chk("wait_valid", {127'd0, valid_out}, 128'd1);
    endtask

    task automatic chk_fields(input string name, input logic [INSTRW-1:0] f);
        chk(name, {54'd0, opcode, key_addr, text_addr, dest_addr}, {54'd0, f});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [INSTRW-1:0] fa, fb, fr;
        logic [95:0]       rw;
        int                d0, e0, o0, nb, n_full;

        rst = 1'b1;
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        ready_in_aes = 1'b0; ready_in_sha = 1'b0;
        repeat (3) @(negedge clk);
        fork compare_loop(); join_none
        chk("reset_outputs", {52'd0, valid_out, busy, frame_err, overrun_err,
                              opcode, key_addr, text_addr, dest_addr}, 128'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single frame, AES ready
        ready_in_aes = 1'b1;
        fa = mk(2'b00, 24'h123456, 24'hABCDEF, 24'h0F0F0F);
        d0 = delivered.size();
        fork
            send_frame(fa, INSTRW, 1'b0);
            begin
                wait_valid();
                chk("t1_key", {104'd0, key_addr}, {104'd0, 24'h123456});
                chk("t1_text", {104'd0, text_addr}, {104'd0, 24'hABCDEF});
                chk("t1_dest", {104'd0, dest_addr}, {104'd0, 24'h0F0F0F});
                @(negedge clk);
                chk("t1_pulse_end", {127'd0, valid_out}, 128'd0);
            end
        join
        chk("t1_delivered_n", 128'(delivered.size() - d0), 128'd1);
        chk("t1_delivered", {54'd0, delivered[$]}, {54'd0, fa});
        chk("t1_no_err", 128'(ferr_seen + ovr_seen), 128'd0);

        // back-pressure on SHA
        ready_in_aes = 1'b0;
        fa = mk(2'b01, 24'hC0FFEE, 24'h00BEEF, 24'h777777);
        d0 = delivered.size();
        send_frame(fa, INSTRW, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_held_valid", {127'd0, valid_out}, 128'd1);
        chk_fields("t2_held_fields", fa);
        ready_in_aes = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_aes_no_effect", {127'd0, valid_out}, 128'd1);
        ready_in_aes = 1'b0;
        ready_in_sha = 1'b1;
        @(negedge clk);
        ready_in_sha = 1'b0;
        chk("t2_dropped", {127'd0, valid_out}, 128'd0);
        repeat (5) @(negedge clk);
        chk("t2_delivered_n", 128'(delivered.size() - d0), 128'd1);

        // short frame then a good one
        e0 = ferr_seen;
        send_frame(mk(2'b10, 24'h111111, 24'h222222, 24'h333333), 40, 1'b0);
        chk("t3_ferr_once", 128'(ferr_seen - e0), 128'd1);
        chk("t3_no_valid", {127'd0, valid_out}, 128'd0);
        ready_in_aes = 1'b1;
        fa = mk(2'b00, 24'hA5A5A5, 24'h5A5A5A, 24'h010203);
        send_frame(fa, INSTRW, 1'b0);
        chk("t3_next_frame", {54'd0, delivered[$]}, {54'd0, fa});

        // overrun: B dropped while A held
        ready_in_aes = 1'b0;
        fa = mk(2'b00, 24'hAAAA01, 24'hAAAA02, 24'hAAAA03);
        fb = mk(2'b00, 24'hBBBB01, 24'hBBBB02, 24'hBBBB03);
        o0 = ovr_seen;
        d0 = delivered.size();
        send_frame(fa, INSTRW, 1'b0);
        send_frame(fb, INSTRW, 1'b0);
        chk("t4_ovr_once", 128'(ovr_seen - o0), 128'd1);
        chk_fields("t4_still_a", fa);
        ready_in_aes = 1'b1;
        @(negedge clk);
        ready_in_aes = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_only_a_n", 128'(delivered.size() - d0), 128'd1);
        chk("t4_only_a", {54'd0, delivered[$]}, {54'd0, fa});

        // B commits in the very cycle A is accepted
        fa = mk(2'b00, 24'hCCCC01, 24'hCCCC02, 24'hCCCC03);
        fb = mk(2'b00, 24'hDDDD01, 24'hDDDD02, 24'hDDDD03);
        send_frame(fa, INSTRW, 1'b0);
        o0 = ovr_seen;
        fork
            send_frame(fb, INSTRW, 1'b0);
            begin
                @(ev_last);
                repeat (3) @(negedge clk);
                ready_in_aes = 1'b1;
                @(negedge clk);
                ready_in_aes = 1'b0;
            end
        join
        chk("t5_no_ovr", 128'(ovr_seen - o0), 128'd0);
        chk("t5_a_delivered", {54'd0, delivered[$]}, {54'd0, fa});
        chk("t5_valid", {127'd0, valid_out}, 128'd1);
        chk_fields("t5_fields_b", fb);
        ready_in_aes = 1'b1;
        @(negedge clk);
        ready_in_aes = 1'b0;

        // reset after 30 bits of a frame
        send_frame(mk(2'b11, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), 30, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        commit_due = -1;
        ferr_due = -1;
        #1;
        chk("t6_reset_outputs", {52'd0, valid_out, busy, frame_err, overrun_err,
                                 opcode, key_addr, text_addr, dest_addr}, 128'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        fa = mk(2'b00, 24'h0A0B0C, 24'h0D0E0F, 24'h102030);
        ready_in_aes = 1'b1;
        fork
            send_frame(fa, INSTRW, 1'b0);
            begin
                wait_valid();
                chk_fields("t6_fresh_frame", fa);
            end
        join

        // random frames, lengths and ready patterns
        d0 = delivered.size();
        o0 = ovr_seen;
        n_full = 0;
        fork
            while (!stop_rand) begin
                @(negedge clk);
                ready_in_aes = ($urandom_range(0, 3) == 0);
                ready_in_sha = ($urandom_range(0, 3) == 0);
            end
        join_none
        for (int n = 0; n < 25; n++) begin
            rw = {$urandom(), $urandom(), $urandom()};
            fr = rw[INSTRW-1:0];
            nb = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 73)) : int'($urandom_range(74, 77));
            if (nb >= INSTRW) n_full++;
            send_frame(fr, nb, 1'b0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        stop_rand = 1'b1;
        repeat (2) @(negedge clk);
        ready_in_aes = 1'b1;
        ready_in_sha = 1'b1;
        repeat (5) @(negedge clk);
        chk("rand_drained", {127'd0, valid_out}, 128'd0);
        chk("rand_conservation", 128'(delivered.size() - d0 + ovr_seen - o0), 128'(n_full));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
